// File: rtl/screen_sel_ctl.sv
// Screen selector for the PONG display path: menu FSM, shared settings registers
// and a registered N-way mux of per-screen VGA streams. Screen changes land on vblank.
module screen_sel_ctl #(
  parameter int NUM_SCREENS  = 4,
  parameter int NUM_DIFF     = 2,
  parameter int NUM_PALETTES = 7,
  parameter int BTN_X0       = 362,
  parameter int BTN_X1       = 674,
  parameter int BTN_Y0       = 46,
  parameter int BTN_H        = 100,
  parameter int BTN_PITCH    = 192
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vblnk_in,
  input  logic [11:0]               xpos,
  input  logic [11:0]               ypos,
  input  logic                      mouse_left,
  input  logic                      button,
  input  logic [NUM_SCREENS-1:0]    vsync_scr,
  input  logic [NUM_SCREENS-1:0]    hsync_scr,
  input  logic [12*NUM_SCREENS-1:0] rgb_scr,
  output logic                      vsync_out,
  output logic                      hsync_out,
  output logic [11:0]               rgb_out,
  output logic [2:0]                screen_sel,
  output logic [1:0]                difficulty,
  output logic [11:0]               color1,
  output logic [11:0]               color2
);

  typedef enum logic [1:0] {MENU, WAIT_IN, SCREEN, WAIT_OUT} state_t;

  localparam int          NUM_ROWS = NUM_SCREENS + 1;
  localparam logic [31:0] X0       = 32'(BTN_X0);
  localparam logic [31:0] X1       = 32'(BTN_X1);
  localparam logic [3:0]  DIFF_ROW = 4'(NUM_SCREENS - 1);
  localparam logic [1:0]  DIFF_MAX = 2'(NUM_DIFF - 1);
  localparam logic [2:0]  PAL_MAX  = 3'(NUM_PALETTES - 1);

  state_t      state, state_next;
  logic        mouse_left_q, button_q, vblnk_q;
  logic        click, press, vb_rise;
  logic [31:0] x32, y32, row_top;
  logic        x_in, hit;
  logic [3:0]  hit_row;
  logic [2:0]  target, palette;
  logic        load_target, take_target, clear_sel, bump_diff, bump_pal;
  logic        mux_vsync, mux_hsync;
  logic [11:0] mux_rgb;

  // ---------------------------------------------------------------------------
  // Edge detection: one action per press, however long the level is held.
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments in every clocked block, so all registers
  // sample pre-edge values and the order of statements cannot matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mouse_left_q <= 1'b0;
      button_q     <= 1'b0;
      vblnk_q      <= 1'b0;
    end else begin
      mouse_left_q <= mouse_left;
      button_q     <= button;
      vblnk_q      <= vblnk_in;
    end
  end

  assign click   = mouse_left & ~mouse_left_q;
  assign press   = button & ~button_q;
  assign vb_rise = vblnk_in & ~vblnk_q;

  // ---------------------------------------------------------------------------
  // Menu button hit decode. Rows never overlap (pitch > height), so at most one
  // row matches and loop order is irrelevant.
  // ---------------------------------------------------------------------------
  assign x32  = {20'd0, xpos};
  assign y32  = {20'd0, ypos};
  assign x_in = (x32 >= X0) && (x32 <= X1);

  // NOTE: every variable written here gets a default first, otherwise a path
  // that skips the assignment would infer a latch.
  always_comb begin
    hit     = 1'b0;
    hit_row = '0;
    row_top = '0;
    for (int k = 0; k < NUM_ROWS; k++) begin
      row_top = 32'(BTN_Y0 + k * BTN_PITCH);
      if (x_in && (y32 >= row_top) && (y32 <= row_top + 32'(BTN_H - 1))) begin
        hit     = 1'b1;
        hit_row = 4'(k);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Menu FSM: state register, next-state logic, action strobes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= MENU;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MENU:     if (click && hit && (hit_row < DIFF_ROW)) state_next = WAIT_IN;
      WAIT_IN: begin
        // A cancel beats a simultaneous vblank.
        if (press)        state_next = MENU;
        else if (vb_rise) state_next = SCREEN;
      end
      SCREEN:   if (press)   state_next = WAIT_OUT;
      WAIT_OUT: if (vb_rise) state_next = MENU;
      default:  state_next = MENU;
    endcase
  end

  always_comb begin
    load_target = 1'b0;
    take_target = 1'b0;
    clear_sel   = 1'b0;
    bump_diff   = 1'b0;
    bump_pal    = 1'b0;
    case (state)
      MENU: begin
        if (click && hit) begin
          if (hit_row < DIFF_ROW)       load_target = 1'b1;
          else if (hit_row == DIFF_ROW) bump_diff   = 1'b1;
          else                          bump_pal    = 1'b1;
        end
      end
      WAIT_IN:  take_target = vb_rise & ~press;
      WAIT_OUT: clear_sel   = vb_rise;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Selection and shared settings. Strobes only fire in MENU for the settings,
  // so difficulty and palette are frozen while a screen owns the mouse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      target     <= '0;
      screen_sel <= '0;
      difficulty <= '0;
      palette    <= '0;
    end else begin
      if (load_target) target <= 3'(hit_row + 4'd1);
      if (take_target)    screen_sel <= target;
      else if (clear_sel) screen_sel <= '0;
      if (bump_diff) difficulty <= (difficulty == DIFF_MAX) ? 2'd0 : difficulty + 2'd1;
      if (bump_pal)  palette    <= (palette == PAL_MAX) ? 3'd0 : palette + 3'd1;
    end
  end

  always_comb begin
    color1 = 12'h000;
    color2 = 12'hFFF;
    case (palette)
      3'd0: begin color1 = 12'h000; color2 = 12'hFFF; end
      3'd1: begin color1 = 12'h099; color2 = 12'hF66; end
      3'd2: begin color1 = 12'h909; color2 = 12'h6F6; end
      3'd3: begin color1 = 12'h990; color2 = 12'h66F; end
      3'd4: begin color1 = 12'h009; color2 = 12'hFF6; end
      3'd5: begin color1 = 12'h900; color2 = 12'h6FF; end
      3'd6: begin color1 = 12'h090; color2 = 12'hF6F; end
      3'd7: begin color1 = 12'h444; color2 = 12'hFF0; end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stream mux, registered for one clock of latency on every screen path.
  // ---------------------------------------------------------------------------
  always_comb begin
    mux_vsync = vsync_scr[0];
    mux_hsync = hsync_scr[0];
    mux_rgb   = rgb_scr[11:0];
    for (int i = 1; i < NUM_SCREENS; i++) begin
      if (screen_sel == 3'(i)) begin
        mux_vsync = vsync_scr[i];
        mux_hsync = hsync_scr[i];
        mux_rgb   = rgb_scr[12*i +: 12];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_out <= 1'b0;
      hsync_out <= 1'b0;
      rgb_out   <= '0;
    end else begin
      vsync_out <= mux_vsync;
      hsync_out <= mux_hsync;
      rgb_out   <= mux_rgb;
    end
  end

endmodule
